// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: shared types and constants for the serial parity checker.
//   state_e       - frame FSM state encoding (IDLE/DATA/PARITY)
//   ERR_COUNT_W   - width of the error-frame counter
//   ERR_COUNT_MAX - saturation value of the error-frame counter
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int                     ERR_COUNT_W   = 8;
  localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = 8'd255;

endpackage

// File: rtl/parity_acc.sv
// parity_acc: running-XOR accumulator for serial parity.
//   clk, rst_n - clock, async active-low reset
//   clr_i      - drop the accumulated value this cycle
//   en_i       - fold bit_i into the accumulator this cycle
//   bit_i      - serial data bit
//   parity_o   - XOR of all bits folded in since the last clear
// clr_i and en_i together clear and seed with bit_i in one cycle.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic parity_o
);

  logic acc_q, acc_d;

  always_comb begin
    acc_d = (clr_i ? 1'b0 : acc_q) ^ (en_i & bit_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_d;
  end

  assign parity_o = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: receives LSB-first serial frames of DATA_W data bits
// followed by one parity bit and reports the parity result.
//   clk, rst_n  - clock, async active-low reset (synchronous release)
//   bit_valid   - bit_in is valid this cycle (bit_valid=0 stalls everything)
//   bit_in      - serial bit, LSB first
//   start       - with bit_valid, marks data bit 0 (aborts any frame in flight)
//   data_out    - last completed frame's data word
//   out_valid   - one-cycle pulse, cycle after the parity bit is accepted
//   parity_err  - parity result of the last completed frame
//   busy        - a frame is in progress (state DATA or PARITY)
//   err_count   - saturating count of frames with parity errors
// Parameters: DATA_W (1..32), ODD_PARITY (0 even, 1 odd).
// Macro SERIAL_PARITY_ERR_COUNT_EN enables the error counter; otherwise
// err_count is tied to zero and no counter flops exist.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  input  logic                   start,
  output logic [DATA_W-1:0]      data_out,
  output logic                   out_valid,
  output logic                   parity_err,
  output logic                   busy,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  // After the start bit, the next data bit index (0 when the frame is 1 bit).
  localparam logic [IDX_W-1:0] IDX_AFTER_START = (DATA_W > 1) ? IDX_W'(1) : '0;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_out_q;
  logic              out_valid_q;
  logic              parity_err_q;

  logic acc_clr, acc_en, acc_parity;
  logic frame_done;
  logic perr_d;
  logic odd_c;

  assign odd_c = (ODD_PARITY != 0);

  parity_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .bit_i   (bit_in),
    .parity_o(acc_parity)
  );

  // Only meaningful in the cycle the parity bit is accepted.
  assign perr_d = acc_parity ^ bit_in ^ odd_c;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    frame_done = 1'b0;
    if (bit_valid) begin
      if (start) begin
        // Start wins in every state: a frame in flight is dropped silently.
        shift_d    = '0;
        shift_d[0] = bit_in;
        idx_d      = IDX_AFTER_START;
        acc_clr    = 1'b1;
        acc_en     = 1'b1;
        state_d    = (DATA_W == 1) ? PARITY : DATA;
      end else begin
        case (state_q)
          DATA: begin
            shift_d[idx_q] = bit_in;
            acc_en         = 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = PARITY;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          PARITY: begin
            frame_done = 1'b1;
            idx_d      = '0;
            state_d    = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      out_valid_q <= frame_done;
      // Output word only moves on completion, so partial frames never show.
      if (frame_done) begin
        data_out_q   <= shift_q;
        parity_err_q <= perr_d;
      end
    end
  end

`ifdef SERIAL_PARITY_ERR_COUNT_EN
  logic [ERR_COUNT_W-1:0] err_cnt_q;

  // Updates at the same edge as out_valid, so the count is current in the
  // pulse cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                err_cnt_q <= '0;
    else if (frame_done && perr_d && err_cnt_q != ERR_COUNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even-parity and an odd-parity instance
// share one stimulus stream; expectations come from frame-level arithmetic
// (popcount of data plus parity bit) and a simple saturating error tally.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       start = 1'b0;

  logic [7:0] dout_e, dout_o, ec_e, ec_o;
  logic       ov_e, ov_o, pe_e, pe_o, busy_e, busy_o;

  int tests = 0, fails = 0;
  int ov_cnt_e = 0, ov_cnt_o = 0;
  int errs_e = 0, errs_o = 0;
  logic [7:0] last_data = 8'h00;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .start(start),
    .data_out(dout_e), .out_valid(ov_e), .parity_err(pe_e), .busy(busy_e), .err_count(ec_e)
  );

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .start(start),
    .data_out(dout_o), .out_valid(ov_o), .parity_err(pe_o), .busy(busy_o), .err_count(ec_o)
  );

  always @(negedge clk) begin
    if (ov_e) ov_cnt_e++;
    if (ov_o) ov_cnt_o++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int e);
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    return (e > 255) ? 255 : e;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input logic bv, input logic st, input logic b);
    bit_valid = bv;
    start     = st;
    bit_in    = b;
    @(posedge clk);
    #1;
  endtask

  // One full frame; the parity bit is followed directly by whatever the
  // caller drives next, so consecutive calls are back-to-back.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input int stall_at, input int stall_n);
    int ee, eo;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i == 0), d[i]);
      if (i == 3) begin
        chk("no_partial", dout_e, last_data);
        chk("busy_mid", busy_e, 1);
      end
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          // start and bit_in are noise while bit_valid is low
          tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          chk("busy_stall", busy_e, 1);
        end
      end
    end
    tick(1'b1, 1'b0, p);
    ee = ($countones(d) + int'(p)) % 2;
    eo = 1 - ee;
    errs_e += ee;
    errs_o += eo;
    last_data = d;
    chk("ov_even", ov_e, 1);
    chk("ov_odd", ov_o, 1);
    chk("dout_even", dout_e, d);
    chk("dout_odd", dout_o, d);
    chk("perr_even", pe_e, ee);
    chk("perr_odd", pe_o, eo);
    chk("busy_done", busy_e, 0);
    chk("errcnt_even", ec_e, exp_cnt(errs_e));
    chk("errcnt_odd", ec_o, exp_cnt(errs_o));
  endtask

  initial begin
    int ov0;
    logic [7:0] d;

    // reset state
    #12;
    chk("rst_dout", dout_e, 0);
    chk("rst_ov", ov_e, 0);
    chk("rst_perr", pe_e, 0);
    chk("rst_busy", busy_e, 0);
    chk("rst_errcnt", ec_e, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // bit_valid without start in IDLE is ignored
    ov0 = ov_cnt_e;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      chk("idle_ignore_busy", busy_e, 0);
    end

    // directed frames
    send_frame(8'hA5, 1'b0, -1, 0);
    send_frame(8'hA5, 1'b1, -1, 0);
    send_frame(8'h01, 1'b0, -1, 0);
    send_frame(8'h01, 1'b1, -1, 0);
    send_frame(8'h3C, 1'b0, 4, 3);
    tick(1'b0, 1'b0, 1'b0);
    chk("ov_count_directed", ov_cnt_e - ov0, 5);

    // abort from DATA after 5 bits, then abort from PARITY after 8 bits
    ov0 = ov_cnt_e;
    for (int i = 0; i < 5; i++) tick(1'b1, (i == 0), 1'($urandom_range(0, 1)));
    send_frame(8'h81, 1'b0, -1, 0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, (i == 0), 1'($urandom_range(0, 1)));
    chk("busy_in_parity", busy_e, 1);
    send_frame(8'h5A, 1'b1, -1, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("ov_count_abort", ov_cnt_e - ov0, 2);

    // reset mid-frame
    ov0 = ov_cnt_e;
    for (int i = 0; i < 3; i++) tick(1'b1, (i == 0), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_e, 0);
    chk("midrst_dout", dout_e, 0);
    chk("midrst_perr", pe_e, 0);
    chk("midrst_ov", ov_e, 0);
    chk("midrst_errcnt", ec_e, 0);
    errs_e = 0;
    errs_o = 0;
    last_data = 8'h00;
    tick(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    chk("ov_count_reset", ov_cnt_e - ov0, 0);
    chk("postrst_busy", busy_e, 0);

    // randomized frames with random stalls and idle gaps
    ov0 = ov_cnt_e;
    for (int f = 0; f < 40; f++) begin
      d = 8'($urandom);
      send_frame(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("ov_count_random", ov_cnt_e - ov0, 40);

    // 260 back-to-back error frames on the even instance
    ov0 = ov_cnt_e;
    for (int f = 0; f < 260; f++) begin
      d = 8'($urandom);
      send_frame(d, ~(^d), -1, 0);
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("ov_count_b2b", ov_cnt_e - ov0, 260);
    chk("ov_count_b2b_odd", ov_cnt_o - ov0, 260);
    chk("errcnt_sat", ec_e, exp_cnt(errs_e));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0: 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk SHALL be an input, 1 bit wide: the system clock, rising-edge active.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 Port bit_valid SHALL be an input, 1 bit wide: bit_in is valid this cycle.
REQ-007 Port bit_in SHALL be an input, 1 bit wide: the serial bit, LSB first.
REQ-008 Port start SHALL be an input, 1 bit wide: qualifies bit_valid as the first data bit of a frame.
REQ-009 Port data_out SHALL be an output, DATA_W bits wide: the last completed frame's data word.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: a one-cycle pulse marking a completed frame.
REQ-011 Port parity_err SHALL be an output, 1 bit wide: the parity result of the last completed frame.
REQ-012 Port busy SHALL be an output, 1 bit wide: high while a frame is in progress.
REQ-013 Port err_count SHALL be an output, 8 bits wide: the saturating count of frames with errors (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, DATA and PARITY.
REQ-015 In IDLE, a cycle with bit_valid=1 and start=1 SHALL capture bit_in as data bit 0, clear and seed the parity accumulator, and move to DATA (or to PARITY when DATA_W=1).
REQ-016 In IDLE, bit_valid=1 with start=0 SHALL be ignored.
REQ-017 In DATA, each bit_valid=1 cycle SHALL store bit_in at the next index and XOR it into the accumulator.
REQ-018 The DATA state SHALL move to PARITY once bit DATA_W-1 is stored.
REQ-019 In PARITY, a bit_valid=1 cycle SHALL take bit_in as the parity bit and return the FSM to IDLE.
REQ-020 Cycles with bit_valid=0 SHALL stall the FSM with no state change, bit index change or accumulator change.
REQ-021 In the cycle after the parity bit is accepted, out_valid SHALL be 1, data_out SHALL hold the frame, and parity_err SHALL be (accumulator XOR parity bit XOR ODD_PARITY).
REQ-022 Latency SHALL be 1 cycle from the parity bit to out_valid.
REQ-023 The data_out and parity_err outputs SHALL hold their values until the next frame completes.
REQ-024 During a frame, data_out SHALL never show partial data.
REQ-025 The busy output SHALL be 1 exactly when the state is DATA or PARITY.
REQ-026 A cycle with start=1 and bit_valid=1 in DATA or PARITY SHALL abort the current frame (no out_valid, no count update) and restart with bit_in as data bit 0.
REQ-027 The start input SHALL be ignored when bit_valid=0.
REQ-028 A new start bit in the same cycle that out_valid pulses SHALL be accepted normally, giving back-to-back frames with no dead cycle.

Reset
REQ-029 On rst_n=0, the block SHALL asynchronously set state=IDLE, bit index=0, accumulator=0, data_out=0, out_valid=0, parity_err=0 and err_count=0.
REQ-030 A reset mid-frame SHALL discard the partial frame with no out_valid.
REQ-031 Reset release SHALL be synchronous to clk.

Configuration
REQ-032 The block SHALL support the macro SERIAL_PARITY_ERR_COUNT_EN.
REQ-033 With SERIAL_PARITY_ERR_COUNT_EN defined, err_count SHALL increment on each out_valid cycle with parity_err=1 and saturate at 255.
REQ-034 With SERIAL_PARITY_ERR_COUNT_EN undefined, err_count SHALL be tied to 0 and no counter flops SHALL be synthesized.

Structure
REQ-035 Package serial_parity_pkg SHALL hold the state typedef (IDLE/DATA/PARITY), the ERR_COUNT_W=8 constant and the ERR_COUNT_MAX=255 constant.
REQ-036 The running-XOR register (clear, enable, bit in, parity out) SHALL be one sub-module, parity_acc, instantiated once.

Verification
REQ-037 Even-parity frame test: DATA_W=8, ODD_PARITY=0, bits of 0xA5 LSB first (1,0,1,0,0,1,0,1) then parity 0 -> out_valid=1 one cycle after the parity bit, data_out=0xA5, parity_err=0.
REQ-038 Parity-error frame test: same frame with parity bit 1 -> parity_err=1; err_count=1 with the macro defined, 0 without.
REQ-039 Odd-parity test: ODD_PARITY=1, data 0x01 with parity bit 0 -> parity_err=0; with parity bit 1 -> parity_err=1.
REQ-040 Stall test: frame 0x3C with bit_valid=0 inserted for 3 cycles after bit 4 -> data_out=0x3C and busy held at 1 through the stall.
REQ-041 Abort/reset test: start+bit_valid after 5 bits, then frame 0x81 -> exactly one out_valid, with data_out=0x81; rst_n low after 3 bits -> no out_valid, busy=0, all outputs 0.
REQ-042 Saturation and back-to-back test: 260 consecutive error frames with no gaps -> err_count=255 and 260 out_valid pulses.
